// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controller.
package cache_pkg;
  typedef enum logic {IDLE, FILL} fill_state_t;

  localparam int              BLOCK_BYTES       = 16;
  localparam int              WORDS_PER_BLOCK   = 8;
  localparam logic [15:0]     BLOCK_OFFSET_MASK = 16'hFFF0;
  localparam int              MEM_LATENCY       = 4;
endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag.
module fill_counter #(
  parameter int CNT_W = 3,
  parameter int TERM  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W:0]   count,
  output logic             termCount
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + (CNT_W + 1)'(1);
    end
  end

  assign termCount = (count == (CNT_W + 1)'(TERM));
endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: fetches one block word-by-word and writes the tag at the end.
//   state | meaning
//   IDLE  | no fill active; busy mirrors miss_detected
//   FILL  | issuing block reads and collecting returned words
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic [CNT_W-1:0]  fill_word_idx,
  output logic              write_tag_array
);
  import cache_pkg::*;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ~ADDR_W'(BLOCK_BYTES - 1);

  fill_state_t       state, stateNext;
  logic [ADDR_W-1:0] base;
  logic [CNT_W:0]    issueCnt, recvCnt;
  logic              issueDone, recvLast;
  logic              cntClear, issueEn, recvEn;

  fill_counter #(.CNT_W(CNT_W), .TERM(WORDS_PER_BLOCK)) uIssueCnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cntClear),
    .enable    (issueEn),
    .count     (issueCnt),
    .termCount (issueDone)
  );

  fill_counter #(.CNT_W(CNT_W), .TERM(WORDS_PER_BLOCK - 1)) uRecvCnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cntClear),
    .enable    (recvEn),
    .count     (recvCnt),
    .termCount (recvLast)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= stateNext;
      if (cntClear) begin
        base <= miss_address & OFFSET_MASK;
      end
    end
  end

  always_comb begin
    stateNext        = state;
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_idx    = '0;
    write_tag_array  = 1'b0;
    cntClear         = 1'b0;
    issueEn          = 1'b0;
    recvEn           = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so the stall request is low while reset is held.
        fsm_busy = miss_detected && rst_n;
        if (miss_detected) begin
          cntClear  = 1'b1;
          stateNext = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issueDone) begin
          mem_rd_en      = 1'b1;
          memory_address = base + ADDR_W'({issueCnt, 1'b0});
          issueEn        = 1'b1;
        end
        // A valid with no outstanding request is spurious and dropped.
        if (memory_data_valid && (recvCnt < issueCnt)) begin
          write_data_array = 1'b1;
          fill_word_idx    = recvCnt[CNT_W-1:0];
          recvEn           = 1'b1;
          if (recvLast) begin
            write_tag_array = 1'b1;
            stateNext       = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm with a schedule-based reference model.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic        mem_rd_en;
  logic [15:0] memory_address;
  logic        fsm_busy;
  logic        write_data_array;
  logic [2:0]  fill_word_idx;
  logic        write_tag_array;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8), .CNT_W(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .mem_rd_en         (mem_rd_en),
    .memory_address    (memory_address),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .fill_word_idx     (fill_word_idx),
    .write_tag_array   (write_tag_array)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
    $fatal(1);
  end

  // One full fill from its miss cycle (cycle 0) through the tag-write cycle.
  // Memory returns word k MEM_LATENCY cycles after its request, plus extra[k], in order.
  task automatic run_fill(input logic [15:0] addr, input int extra[8], input bit toggleMiss,
                          input string name);
    logic [15:0] base;
    int          validT[8];
    int          lastT, word, t;
    logic [22:0] expV, obsV;
    logic        eRd, eWd;
    logic [15:0] eAddr;
    logic [2:0]  eIdx;
    base = 16'((addr / 16) * 16);
    for (int k = 0; k < 8; k++) begin
      t = k + 1 + MEM_LATENCY + extra[k];
      if (k > 0 && t <= validT[k-1]) t = validT[k-1] + 1;
      validT[k] = t;
    end
    lastT = validT[7];
    for (int c = 0; c <= lastT; c++) begin
      miss_detected = (c == 0) ? 1'b1 : (toggleMiss ? 1'($urandom_range(0, 1)) : 1'b1);
      miss_address  = (c == 0) ? addr : (toggleMiss ? 16'($urandom) : addr);
      word = -1;
      for (int k = 0; k < 8; k++) if (validT[k] == c) word = k;
      memory_data_valid = (word >= 0);
      @(negedge clk);
      eRd   = (c >= 1 && c <= 8);
      eAddr = eRd ? 16'(base + 2 * (c - 1)) : 16'h0000;
      eWd   = (word >= 0);
      eIdx  = eWd ? 3'(word) : 3'd0;
      expV  = {1'b1, eRd, eAddr, eWd, eIdx, (c == lastT)};
      obsV  = {fsm_busy, mem_rd_en, memory_address, write_data_array, fill_word_idx, write_tag_array};
      nTests++;
      if (obsV !== expV) begin
        nFail++;
        $display("FAIL %s cycle %0d: got busy=%b rd=%b addr=%h wr=%b idx=%0d tag=%b, expected busy=%b rd=%b addr=%h wr=%b idx=%0d tag=%b",
                 name, c, obsV[22], obsV[21], obsV[20:5], obsV[4], obsV[3:1], obsV[0],
                 expV[22], expV[21], expV[20:5], expV[4], expV[3:1], expV[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Idle cycles with no miss: every output must stay low, optionally with stray valids.
  task automatic idle_check(input int n, input bit strayValid, input string name);
    for (int c = 0; c < n; c++) begin
      miss_detected     = 1'b0;
      miss_address      = 16'($urandom);
      memory_data_valid = strayValid ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      nTests++;
      if ({fsm_busy, mem_rd_en, memory_address, write_data_array, fill_word_idx, write_tag_array} !== 23'd0) begin
        nFail++;
        $display("FAIL %s idle %0d: got busy=%b rd=%b addr=%h wr=%b idx=%0d tag=%b, expected all 0",
                 name, c, fsm_busy, mem_rd_en, memory_address, write_data_array, fill_word_idx,
                 write_tag_array);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    miss_detected = 1'b1;
    miss_address = 16'h1234;
    memory_data_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nTests++;
      if ({fsm_busy, mem_rd_en, memory_address, write_data_array, fill_word_idx, write_tag_array} !== 23'd0) begin
        nFail++;
        $display("FAIL reset_hold cycle %0d: got busy=%b rd=%b addr=%h wr=%b tag=%b, expected all 0",
                 c, fsm_busy, mem_rd_en, memory_address, write_data_array, write_tag_array);
      end
    end
    @(posedge clk); #1;
    miss_detected = 1'b0;
    memory_data_valid = 1'b0;
    rst_n = 1'b1;
    idle_check(2, 1'b0, "reset_release");
  endtask

  task automatic test_reset_mid_fill();
    for (int c = 0; c < 6; c++) begin
      miss_detected     = 1'b1;
      miss_address      = 16'h1234;
      memory_data_valid = (c == 5);
      @(negedge clk);
      nTests++;
      if (fsm_busy !== 1'b1 || mem_rd_en !== (c >= 1)) begin
        nFail++;
        $display("FAIL reset_mid_fill pre cycle %0d: got busy=%b rd=%b, expected busy=1 rd=%b",
                 c, fsm_busy, mem_rd_en, (c >= 1));
      end
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    nTests++;
    if ({fsm_busy, mem_rd_en, memory_address, write_data_array, fill_word_idx, write_tag_array} !== 23'd0) begin
      nFail++;
      $display("FAIL reset_mid_fill async: got busy=%b rd=%b addr=%h wr=%b tag=%b, expected all 0",
               fsm_busy, mem_rd_en, memory_address, write_data_array, write_tag_array);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 8; c <= 16; c++) begin
      miss_detected     = 1'b0;
      memory_data_valid = (c <= 12);
      @(negedge clk);
      nTests++;
      if (fsm_busy !== 1'b0 || write_tag_array !== 1'b0 || write_data_array !== 1'b0) begin
        nFail++;
        $display("FAIL reset_mid_fill after cycle %0d: got busy=%b wr=%b tag=%b, expected 0 0 0",
                 c, fsm_busy, write_data_array, write_tag_array);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic_fill();
    int ex[8] = '{default: 0};
    run_fill(16'h1234, ex, 1'b0, "basic_fill");
    idle_check(2, 1'b0, "basic_fill_end");
  endtask

  task automatic test_block_wrap();
    int ex[8] = '{default: 0};
    run_fill(16'hFFFF, ex, 1'b0, "block_wrap");
    idle_check(1, 1'b0, "block_wrap_end");
  endtask

  task automatic test_memory_gap();
    int ex[8] = '{0, 0, 0, 2, 0, 0, 0, 0};
    run_fill(16'h4B6A, ex, 1'b0, "memory_gap");
    idle_check(1, 1'b0, "memory_gap_end");
  endtask

  task automatic test_ignored_inputs();
    int ex[8] = '{default: 0};
    idle_check(6, 1'b1, "idle_stray_valid");
    run_fill(16'h0A5C, ex, 1'b1, "miss_toggle");
    idle_check(4, 1'b1, "ignored_end");
  endtask

  task automatic test_back_to_back();
    int ex[8] = '{default: 0};
    run_fill(16'h1234, ex, 1'b0, "b2b_first");
    run_fill(16'h2000, ex, 1'b0, "b2b_second");
    idle_check(2, 1'b0, "b2b_end");
  endtask

  task automatic test_random();
    int ex[8];
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) ex[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_fill(16'($urandom), ex, 1'($urandom_range(0, 1)), "random_fill");
      if ($urandom_range(0, 2) != 0) idle_check(int'($urandom_range(1, 3)), 1'b1, "random_idle");
    end
    idle_check(1, 1'b0, "random_end");
  endtask

  initial begin
    test_reset();
    test_reset_mid_fill();
    test_basic_fill();
    test_block_wrap();
    test_memory_gap();
    test_ignored_inputs();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
